// File: rtl/clksel_ctrl.sv
//============================================================================
// Module   : clksel_ctrl
// Brief    : CPU clock-speed sequencer. It picks HS or LS and the HS divider,
//            and it only retimes the divider while LS is selected.
//            Optional feature macro: CLKSEL_FORCE_LS_EN (adds force_ls input).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module clksel_ctrl #(
    parameter logic [7:0]  SLOW_PAGE_LO   = 8'h80,
    parameter logic [23:0] CFG_ADDR       = 24'hFF0000,
    parameter int unsigned LS_HOLD_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES  = 3
) (
    input  logic        hsclk_in,
    input  logic        rst,
    input  logic        cyc_strobe,
    input  logic [23:0] addr,
    input  logic        rnw,
    input  logic [7:0]  wdata,
`ifdef CLKSEL_FORCE_LS_EN
    input  logic        force_ls,
`endif
    output logic        hsclk_sel,
    output logic [1:0]  cpuclk_div_sel,
    output logic        cfg_hit,
    output logic [7:0]  cfg_rdata
);

    localparam logic [3:0] c_HOLD_INIT   = 4'(LS_HOLD_CYCLES);
    localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_LS     = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HS     = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_turbo_en;
    logic [1:0]  r_div_req;
    logic [1:0]  r_div_sel;
    logic [3:0]  r_hold_cnt;
    logic [3:0]  r_settle_cnt;
    logic        r_hsclk_sel;
    logic        r_cfg_hit;

    logic        w_force;
    logic        w_cfg_acc;
    logic        w_cfg_wr;
    logic        w_slow;
    logic        w_div_mismatch;
    logic [3:0]  w_hold_next;
    logic        w_unused;

`ifdef CLKSEL_FORCE_LS_EN
    assign w_force = force_ls;
`else
    assign w_force = 1'b0;
`endif

    assign w_cfg_acc      = (addr == CFG_ADDR);
    assign w_cfg_wr       = cyc_strobe && w_cfg_acc && !rnw;
    // turbo_en is the registered value: a config write is judged by the old setting
    assign w_slow         = ((addr[23:16] == 8'h00) && (addr[15:8] >= SLOW_PAGE_LO))
                            || !r_turbo_en || w_force;
    assign w_div_mismatch = (r_div_req != r_div_sel);
    assign w_unused       = ^wdata[6:2];

    // Hold counter update shared by LS and SETTLE
    always_comb begin
        w_hold_next = r_hold_cnt;
        if (cyc_strobe) begin
            if (w_slow) begin
                w_hold_next = c_HOLD_INIT;
            end else if (r_hold_cnt != 4'd0) begin
                w_hold_next = r_hold_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            r_state      <= ST_LS;
            r_turbo_en   <= 1'b0;
            r_div_req    <= 2'b11;
            r_div_sel    <= 2'b11;
            r_hold_cnt   <= c_HOLD_INIT;
            r_settle_cnt <= 4'd0;
            r_hsclk_sel  <= 1'b0;
            r_cfg_hit    <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                r_turbo_en <= wdata[7];
                r_div_req  <= wdata[1:0];
            end
            if (cyc_strobe) begin
                r_cfg_hit <= w_cfg_acc;
            end

            case (r_state)
                ST_LS: begin
                    if (w_div_mismatch) begin
                        r_div_sel    <= r_div_req;
                        r_settle_cnt <= c_SETTLE_INIT;
                        r_state      <= ST_SETTLE;
                    end else if (cyc_strobe && !w_slow && (r_hold_cnt == 4'd0)) begin
                        r_state     <= ST_HS;
                        r_hsclk_sel <= 1'b1;
                    end else begin
                        r_hold_cnt <= w_hold_next;
                    end
                end
                ST_SETTLE: begin
                    r_hold_cnt <= w_hold_next;
                    if (r_settle_cnt <= 4'd1) begin
                        r_settle_cnt <= 4'd0;
                        r_state      <= ST_LS;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_HS: begin
                    // Turbo switched off also drops out of HS without waiting for a strobe
                    if ((cyc_strobe && w_slow) || !r_turbo_en) begin
                        r_state     <= ST_LS;
                        r_hsclk_sel <= 1'b0;
                        r_hold_cnt  <= c_HOLD_INIT;
                    end else if (w_div_mismatch) begin
                        r_state     <= ST_LS;
                        r_hsclk_sel <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_LS;
                    r_hsclk_sel <= 1'b0;
                end
            endcase
        end
    end

    assign hsclk_sel      = r_hsclk_sel;
    assign cpuclk_div_sel = r_div_sel;
    assign cfg_hit        = r_cfg_hit;
    assign cfg_rdata      = {r_turbo_en, w_force, 2'b00, r_state, r_div_req};

endmodule

`default_nettype wire

// File: tb/tb_clksel_ctrl.sv
//============================================================================
// Module   : tb_clksel_ctrl
// Brief    : Scoreboard bench for clksel_ctrl with a reference model that
//            counts fast strobes since the last slow access.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clksel_ctrl;

    localparam logic [7:0]  SLOW_PAGE_LO = 8'h80;
    localparam logic [23:0] CFG_ADDR     = 24'hFF0000;
    localparam int          LS_HOLD      = 4;
    localparam int          SETTLE       = 3;

    logic        hsclk_in = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_strobe = 1'b0;
    logic [23:0] addr = 24'h0;
    logic        rnw = 1'b1;
    logic [7:0]  wdata = 8'h0;
    logic        hsclk_sel;
    logic [1:0]  cpuclk_div_sel;
    logic        cfg_hit;
    logic [7:0]  cfg_rdata;
`ifdef CLKSEL_FORCE_LS_EN
    logic        force_ls = 1'b0;
`endif

    always #5 hsclk_in = ~hsclk_in;

    clksel_ctrl #(
        .SLOW_PAGE_LO   (SLOW_PAGE_LO),
        .CFG_ADDR       (CFG_ADDR),
        .LS_HOLD_CYCLES (LS_HOLD),
        .SETTLE_CYCLES  (SETTLE)
    ) u_dut (
        .hsclk_in       (hsclk_in),
        .rst            (rst),
        .cyc_strobe     (cyc_strobe),
        .addr           (addr),
        .rnw            (rnw),
        .wdata          (wdata),
`ifdef CLKSEL_FORCE_LS_EN
        .force_ls       (force_ls),
`endif
        .hsclk_sel      (hsclk_sel),
        .cpuclk_div_sel (cpuclk_div_sel),
        .cfg_hit        (cfg_hit),
        .cfg_rdata      (cfg_rdata)
    );

    typedef struct packed {
        logic       rst_seen;
        logic       hs;
        logic [1:0] div;
        logic       hit;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: mode 0=LS 1=SETTLE 2=HS; fast_run counts fast strobes since last slow
    int m_turbo, m_div_req, m_div, m_mode, m_fast_run, m_settle_left, m_hit;
    bit done = 1'b0;

    int checks;
    int failures;
    logic       prev_hs;
    logic [1:0] prev_div;
    bit         have_prev = 1'b0;

    task automatic model_edge(input logic s, input logic [23:0] a, input logic r,
                              input logic [7:0] w, input logic rs);
        bit slow_acc;
        bit wr;
        if (rs) begin
            m_turbo = 0; m_div_req = 3; m_div = 3; m_mode = 0;
            m_fast_run = 0; m_settle_left = 0; m_hit = 0;
        end else begin
            slow_acc = ((a[23:16] == 8'h00) && (a[15:8] >= SLOW_PAGE_LO)) || (m_turbo == 0);
            wr = s && (a == CFG_ADDR) && !r;
            if (m_mode == 0) begin
                if (m_div_req != m_div) begin
                    m_div = m_div_req;
                    m_settle_left = SETTLE;
                    m_mode = 1;
                end else if (s) begin
                    if (slow_acc) m_fast_run = 0;
                    else if (m_fast_run >= LS_HOLD) m_mode = 2;
                    else m_fast_run++;
                end
            end else if (m_mode == 1) begin
                if (s) begin
                    if (slow_acc) m_fast_run = 0;
                    else m_fast_run++;
                end
                m_settle_left--;
                if (m_settle_left <= 0) begin
                    m_settle_left = 0;
                    m_mode = 0;
                end
            end else begin
                if ((s && slow_acc) || m_turbo == 0) begin
                    m_fast_run = 0;
                    m_mode = 0;
                end else if (m_div_req != m_div) begin
                    m_mode = 0;
                end
            end
            if (wr) begin
                m_turbo   = int'(w[7]);
                m_div_req = int'(w[1:0]);
            end
            if (s) m_hit = (a == CFG_ADDR) ? 1 : 0;
        end
    endtask

    task automatic step(input logic s, input logic [23:0] a, input logic r,
                        input logic [7:0] w, input logic rs);
        exp_t e;
        rst = rs; cyc_strobe = s; addr = a; rnw = r; wdata = w;
        model_edge(s, a, r, w, rs);
        e.rst_seen = rs;
        e.hs       = (m_mode == 2);
        e.div      = 2'(m_div);
        e.hit      = 1'(m_hit);
        e.rd       = {1'(m_turbo), 3'b000, 2'(m_mode), 2'(m_div_req)};
        @(posedge hsclk_in);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b1, 8'h0, 1'b0);
    endtask

    task automatic strobes(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) step(1'b1, a, 1'b1, 8'h0, 1'b0);
    endtask

    task automatic cfg_write(input logic [7:0] w);
        step(1'b1, CFG_ADDR, 1'b0, w, 1'b0);
    endtask

    task automatic rand_step();
        logic        s, r, rs;
        logic [23:0] a;
        logic [7:0]  w;
        int          k;
        rs = ($urandom_range(0, 299) == 0);
        s  = ($urandom_range(0, 9) < 6);
        r  = 1'b1;
        w  = 8'($urandom);
        k  = $urandom_range(0, 15);
        if (k == 0) begin
            a = CFG_ADDR;
            r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) != 0) w[7] = 1'b1;
        end else if (k <= 3) begin
            a = {8'h00, 8'($urandom_range(8'h80, 8'hFF)), 8'($urandom)};
        end else if (k <= 10) begin
            a = {8'h00, 8'($urandom_range(8'h00, 8'h7F)), 8'($urandom)};
        end else if (k <= 13) begin
            a = {8'($urandom_range(8'h01, 8'hFE)), 16'($urandom)};
        end else if (k == 14) begin
            a = ($urandom_range(0, 1) == 0) ? 24'h007FFF : 24'h008000;
        end else begin
            a = {8'hFF, 8'h00, 8'($urandom_range(1, 255))};
        end
        step(s, a, r, w, rs);
    endtask

    // Stimulus
    initial begin
        @(posedge hsclk_in);
        #1;
        step(1'b0, 24'h0, 1'b1, 8'h0, 1'b1);
        step(1'b0, 24'h0, 1'b1, 8'h0, 1'b1);
        strobes(24'h001000, 6);
        cfg_write(8'h81);
        idle(4);
        strobes(24'h001000, 5);
        idle(2);
        strobes(24'h00FE40, 1);
        strobes(24'h001000, 5);
        idle(1);
        cfg_write(8'h82);
        idle(6);
        strobes(24'h001000, 5);
        step(1'b1, CFG_ADDR, 1'b1, 8'h00, 1'b0);
        strobes(24'h007F00, 2);
        strobes(24'h008000, 1);
        strobes(24'h123456, 6);
        cfg_write(8'h02);
        idle(2);
        cfg_write(8'h80);
        idle(2);
        step(1'b0, 24'h0, 1'b1, 8'h0, 1'b1);
        idle(2);
        for (int i = 0; i < 3000; i++) rand_step();
        idle(2);
        repeat (3) @(posedge hsclk_in);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        checks = 0;
        failures = 0;
        while (!done) begin
            @(negedge hsclk_in);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (hsclk_sel !== e.hs) begin
                    failures++;
                    $display("FAIL hsclk_sel t=%0t actual=%b expected=%b", $time, hsclk_sel, e.hs);
                end
                checks++;
                if (cpuclk_div_sel !== e.div) begin
                    failures++;
                    $display("FAIL div_sel t=%0t actual=%b expected=%b", $time, cpuclk_div_sel, e.div);
                end
                checks++;
                if (cfg_hit !== e.hit) begin
                    failures++;
                    $display("FAIL cfg_hit t=%0t actual=%b expected=%b", $time, cfg_hit, e.hit);
                end
                checks++;
                if (cfg_rdata !== e.rd) begin
                    failures++;
                    $display("FAIL cfg_rdata t=%0t actual=%h expected=%h", $time, cfg_rdata, e.rd);
                end
                if (have_prev && !e.rst_seen && prev_hs) begin
                    checks++;
                    if (cpuclk_div_sel !== prev_div) begin
                        failures++;
                        $display("FAIL div_stable t=%0t actual=%b expected=%b", $time, cpuclk_div_sel, prev_div);
                    end
                end
                prev_hs   = hsclk_sel;
                prev_div  = cpuclk_div_sel;
                have_prev = 1'b1;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
